// File: rtl/iob_ram_2p_clr.sv
// Two-port (one write, one read) RAM with byte strobes and a hardware clear pass.
// After reset, or on a clr request, a counter walks every address writing zero;
// busy is high for that whole pass and the array is closed to user traffic.

module iob_ram_2p_clr #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 1,
    parameter int BYPASS = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    output logic                busy,
    input  logic                w_en,
    input  logic [DATA_W/8-1:0] w_strb,
    input  logic [ADDR_W-1:0]   w_addr,
    input  logic [DATA_W-1:0]   w_data,
    input  logic                r_en,
    input  logic [ADDR_W-1:0]   r_addr,
    output logic [DATA_W-1:0]   r_data,
    output logic                r_valid
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int STRB_W = DATA_W / 8;
    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t state;
    logic [ADDR_W:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word;

    logic accept;
    logic clr_we;
    logic wr_fire;
    logic rd_fire;

    // User traffic is only honoured in READY, and a clr in the same cycle
    // swallows whatever write or read was presented alongside it.
    assign accept  = (state == READY) && !rst;
    assign wr_fire = accept && !clr && w_en;
    assign rd_fire = accept && !clr && r_en;
    assign clr_we  = (state == CLEAR) && !rst;
    assign busy    = (state == CLEAR);

    // Clear sequencer: walk the counter through every address, then open the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    cnt <= cnt + (ADDR_W + 1)'(1);
                    if (cnt == LAST) begin
                        state <= READY;
                    end
                end
                READY: begin
                    if (clr) begin
                        cnt   <= '0;
                        state <= CLEAR;
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Storage array: the clear pass owns the write port while it runs,
    // otherwise only strobed byte lanes of a user write are updated.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[cnt[ADDR_W-1:0]] <= '0;
        end else if (wr_fire) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_strb[b]) begin
                    mem[w_addr][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
        end
    end

    // Read word selection: with bypass on, a colliding write's strobed lanes
    // are forwarded so the reader sees the post-write word.
    always_comb begin
        rd_word = mem[r_addr];
        if ((BYPASS != 0) && w_en && (w_addr == r_addr)) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_strb[b]) begin
                    rd_word[8*b +: 8] = w_data[8*b +: 8];
                end
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] p_data;
            logic              p_valid;

            // First read stage: capture the selected word when a read fires.
            always_ff @(posedge clk) begin
                if (rst) begin
                    p_valid <= 1'b0;
                    p_data  <= '0;
                end else begin
                    p_valid <= rd_fire;
                    if (rd_fire) begin
                        p_data <= rd_word;
                    end
                end
            end

            // Output stage: reads already captured drain even once a clear has begun.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else begin
                    r_valid <= p_valid;
                    if (p_valid) begin
                        r_data <= p_data;
                    end
                end
            end
        end else begin : g_lat1
            // Single-stage read: data register updates only when a read fires.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else begin
                    r_valid <= rd_fire;
                    if (rd_fire) begin
                        r_data <= rd_word;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_iob_ram_2p_clr.sv
// Scoreboard bench for iob_ram_2p_clr: one instance with RD_LAT=1/BYPASS=0 and
// one with RD_LAT=2/BYPASS=1 share stimulus; expected read words are queued
// at issue time and monitors pop them whenever r_valid pulses.

module tb_iob_ram_2p_clr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        w_en = 1'b0;
    logic [3:0]  w_strb = '0;
    logic [3:0]  w_addr = '0;
    logic [31:0] w_data = '0;
    logic        r_en = 1'b0;
    logic [3:0]  r_addr = '0;

    logic        busy1, busy2;
    logic [31:0] rd1, rd2;
    logic        rv1, rv2;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] q1[$];
    logic [31:0] q2[$];
    logic [31:0] model [16];
    logic [31:0] last1 = '0;
    logic [31:0] last2 = '0;
    bit          rst_seen = 1'b1;

    int c1, c2;

    iob_ram_2p_clr #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1), .BYPASS(0)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy1),
        .w_en(w_en), .w_strb(w_strb), .w_addr(w_addr), .w_data(w_data),
        .r_en(r_en), .r_addr(r_addr), .r_data(rd1), .r_valid(rv1)
    );

    iob_ram_2p_clr #(.DATA_W(32), .ADDR_W(4), .RD_LAT(2), .BYPASS(1)) dut2 (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy2),
        .w_en(w_en), .w_strb(w_strb), .w_addr(w_addr), .w_data(w_data),
        .r_en(r_en), .r_addr(r_addr), .r_data(rd2), .r_valid(rv2)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Remember whether the last active edge saw reset, so monitors can flush.
    always @(posedge clk) rst_seen <= rst;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    // Drive one cycle of stimulus, queue the expected read words, update the model.
    task automatic applyStimulus(input bit c, input bit we, input logic [3:0] strb,
                                 input logic [3:0] wa, input logic [31:0] wd,
                                 input bit re, input logic [3:0] ra);
        logic [31:0] old;
        clr = c; w_en = we; w_strb = strb; w_addr = wa; w_data = wd;
        r_en = re; r_addr = ra;
        if (c) begin
            for (int i = 0; i < 16; i++) model[i] = '0;
        end else begin
            if (re) begin
                old = model[ra];
                q1.push_back(old);
                q2.push_back((we && wa == ra) ? merge(old, wd, strb) : old);
            end
            if (we) model[wa] = merge(model[wa], wd, strb);
        end
        @(posedge clk);
        #1;
        clr = 1'b0; w_en = 1'b0; w_strb = '0; w_addr = '0; w_data = '0;
        r_en = 1'b0; r_addr = '0;
    endtask

    // Count busy cycles of each instance, optionally hammering the inputs meanwhile.
    task automatic run_busy(input bit disturb, output int n1, output int n2);
        n1 = 0;
        n2 = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy1 && !busy2) begin
                clr = 1'b0; w_en = 1'b0; w_strb = '0; r_en = 1'b0;
                break;
            end
            if (busy1) n1++;
            if (busy2) n2++;
            if (disturb) begin
                clr    = (n1 == 3) || (n1 == 15);
                w_en   = 1'b1;
                w_strb = 4'hF;
                w_addr = n1[3:0];
                w_data = 32'hFFFF_FFFF;
                r_en   = 1'b1;
                r_addr = n1[3:0];
            end
        end
    endtask

    // Monitor for the latency-1 instance.
    always @(negedge clk) begin
        if (rst_seen) begin
            q1.delete();
            last1 = '0;
            checkOutput("rvalid1_rst", {31'b0, rv1}, 32'h0);
        end else if (rv1) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("[TB] FAIL unexpected1: r_valid=1 data %h, expected no read at %0t", rd1, $time);
            end else begin
                last1 = q1.pop_front();
                checkOutput("rdata1", rd1, last1);
            end
        end else begin
            checkOutput("hold1", rd1, last1);
        end
    end

    // Monitor for the latency-2 bypass instance.
    always @(negedge clk) begin
        if (rst_seen) begin
            q2.delete();
            last2 = '0;
            checkOutput("rvalid2_rst", {31'b0, rv2}, 32'h0);
        end else if (rv2) begin
            if (q2.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("[TB] FAIL unexpected2: r_valid=1 data %h, expected no read at %0t", rd2, $time);
            end else begin
                last2 = q2.pop_front();
                checkOutput("rdata2", rd2, last2);
            end
        end else begin
            checkOutput("hold2", rd2, last2);
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) model[i] = '0;

        // Reset, then re-assert reset at clear count 7; the pass must restart in full.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("busy1_rst", {31'b0, busy1}, 32'h1);
        checkOutput("busy2_rst", {31'b0, busy2}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("busy1_mid_rst", {31'b0, busy1}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        run_busy(1'b0, c1, c2);
        checkOutput("clear_len1_rst", c1, 32'd16);
        checkOutput("clear_len2_rst", c2, 32'd16);

        // Every word reads zero after the pass.
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 4'h0, 4'h0, 32'h0, 1, i[3:0]);

        // Fill with 0x20+i and read back back-to-back.
        for (int i = 0; i < 16; i++) applyStimulus(0, 1, 4'hF, i[3:0], 32'h20 + i, 0, 4'h0);
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 4'h0, 4'h0, 32'h0, 1, i[3:0]);

        // Partial strobes give 0xAA22CC44; an all-zero strobe changes nothing.
        applyStimulus(0, 1, 4'hF, 4'd5, 32'hAABB_CCDD, 0, 4'h0);
        applyStimulus(0, 1, 4'b0101, 4'd5, 32'h1122_3344, 0, 4'h0);
        applyStimulus(0, 0, 4'h0, 4'h0, 32'h0, 1, 4'd5);
        applyStimulus(0, 1, 4'h0, 4'd5, 32'hFFFF_FFFF, 0, 4'h0);
        applyStimulus(0, 0, 4'h0, 4'h0, 32'h0, 1, 4'd5);

        // Read-during-write on addr 3: old word without bypass, new word with it.
        applyStimulus(0, 1, 4'hF, 4'd3, 32'h5, 0, 4'h0);
        applyStimulus(0, 1, 4'hF, 4'd3, 32'h9, 1, 4'd3);
        applyStimulus(0, 0, 4'h0, 4'h0, 32'h0, 1, 4'd3);

        // Different addresses in the same cycle do not interact.
        applyStimulus(0, 1, 4'hF, 4'd4, 32'h77, 1, 4'd6);
        applyStimulus(0, 0, 4'h0, 4'h0, 32'h0, 1, 4'd4);

        // Read just before clr completes; ops alongside clr are dropped;
        // the pass ignores clr, writes and reads while busy.
        applyStimulus(0, 0, 4'h0, 4'h0, 32'h0, 1, 4'd7);
        applyStimulus(1, 1, 4'hF, 4'd2, 32'hDEAD_BEEF, 1, 4'd2);
        run_busy(1'b1, c1, c2);
        checkOutput("clear_len1_clr", c1, 32'd16);
        checkOutput("clear_len2_clr", c2, 32'd16);
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 4'h0, 4'h0, 32'h0, 1, i[3:0]);

        // Drain and confirm every queued read came back.
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("q1_drained", q1.size(), 32'd0);
        checkOutput("q2_drained", q2.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/iob_ram_2p_clr.md
IOB_RAM_2P_CLR -- requirements
Module: iob_ram_2p_clr

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data width in bits, a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 4: address width; depth = 2**ADDR_W words.
REQ-003 SHALL have parameter RD_LAT, default 1: read latency in clock edges; only 1 or 2 are legal.
REQ-004 SHALL have parameter BYPASS, default 0: read-during-write policy; 1 = new data, 0 = old data.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port clr, input, 1: one-cycle request to re-zero the whole array.
REQ-008 SHALL have port busy, output, 1: clear pass in progress; the array is inaccessible.
REQ-009 SHALL have port w_en, input, 1: write enable.
REQ-010 SHALL have port w_strb, input, DATA_W/8: per-byte write enable.
REQ-011 SHALL have port w_addr, input, ADDR_W: write address.
REQ-012 SHALL have port w_data, input, DATA_W: write data.
REQ-013 SHALL have port r_en, input, 1: read enable.
REQ-014 SHALL have port r_addr, input, ADDR_W: read address.
REQ-015 SHALL have port r_data, output, DATA_W: read data, registered.
REQ-016 SHALL have port r_valid, output, 1: one-cycle pulse marking new r_data.

Function
REQ-017 SHALL implement a two-state FSM, CLEAR and READY, with a clear counter of ADDR_W+1 bits.
REQ-018 In CLEAR, SHALL write all-zero to the address held by the counter on each edge, then increment the counter.
REQ-019 SHALL move from CLEAR to READY on the edge that writes address 2**ADDR_W-1, so CLEAR lasts exactly 2**ADDR_W cycles.
REQ-020 SHALL assert busy exactly while the FSM is in CLEAR.
REQ-021 In READY, a clr=1 sample SHALL reset the counter to 0 and enter CLEAR on the next edge.
REQ-022 SHALL ignore clr while busy=1; a clear pass is never restarted by clr.
REQ-023 While busy=1, SHALL ignore w_en and r_en: no array write, no r_valid, and r_data held.
REQ-024 On an edge with clr=1 in READY, SHALL drop any write or read presented in that cycle.
REQ-025 On an edge with w_en=1 in READY, SHALL update only the byte lanes whose w_strb bit is 1; other lanes are unchanged.
REQ-026 When w_en=1 and w_strb is all-zero, SHALL leave the array unchanged.
REQ-027 When r_en=1 is sampled at edge N in READY, SHALL present the word at r_addr on r_data and pulse r_valid=1 after edge N+RD_LAT-1.
REQ-028 When RD_LAT=2, SHALL insert one output pipeline register; reads are fully pipelined, one per cycle.
REQ-029 When r_en=0, SHALL hold r_data at its last value, and r_valid SHALL be 0 for that slot.
REQ-030 On a same-cycle read and write to the same address with BYPASS=1, r_data SHALL return the stored word merged with w_data on the strobed lanes.
REQ-031 On a same-cycle read and write to the same address with BYPASS=0, r_data SHALL return the pre-write word.
REQ-032 A read and a write to different addresses in the same cycle SHALL not interact.
REQ-033 Reads already in the RD_LAT=2 pipeline when clr is accepted SHALL still complete with their captured data.

Reset
REQ-034 On rst=1 at an edge, SHALL set FSM=CLEAR, counter=0, r_data=0, r_valid=0, and flush the read pipeline.
REQ-035 SHALL set busy=1 from the first edge with rst=1; the clear pass starts on the first edge with rst=0.
REQ-036 rst asserted mid-clear or mid-read SHALL restart the clear pass from address 0, with no r_valid emitted for in-flight reads.
REQ-037 Array contents SHALL need no reset other than the clear pass.

Verification (DATA_W=32, ADDR_W=4, RD_LAT=1 unless stated)
REQ-038 Release rst -> busy=1 for exactly 16 cycles; then read all 16 addresses -> r_data=0x00000000 with one r_valid pulse per read.
REQ-039 Write addr i = 0x20+i with w_strb=4'hF, then read back -> r_data=0x20+i one cycle after each r_en; repeat with RD_LAT=2 -> two cycles after.
REQ-040 Write 0xAABBCCDD, then write 0x11223344 with w_strb=4'b0101 -> readback 0xAA22CC44.
REQ-041 Addr 3 holds 0x5; write 0x9 to addr 3 while reading addr 3 in the same cycle -> BYPASS=1 returns 0x9, BYPASS=0 returns 0x5; next read returns 0x9.
REQ-042 Pulse clr after filling the array; also pulse clr again while busy, and drive w_en/r_en while busy -> busy=1 for exactly 16 cycles (no extension), no r_valid while busy, all addresses then read 0.
REQ-043 Assert rst at clear count 7 -> busy stays 1, and the pass restarts with 16 full cycles after rst deasserts.
